// File: rtl/wb_lcd.sv
// Wishbone slave driving an HD44780 character LCD in 8-bit write-only mode.
// Bus writes queue {RS, byte} in a 4-deep FIFO; a timed FSM replays each entry onto the LCD bus.
module wb_lcd #(
    parameter int T_SU   = 2,
    parameter int T_E    = 12,
    parameter int T_EXEC = 1850,
    parameter int T_CLR  = 76000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data,
    output logic        lcd_bl
);

    localparam int CNT_W = ($clog2(T_CLR + 1) > 17) ? $clog2(T_CLR + 1) : 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tmr_q, tmr_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;

    logic               ack_q;
    logic [31:0]        dat_q, dat_d;
    logic               ctrl_q;
    logic               ovf_q, ovf_d;

    logic [8:0]         fifo_q [4];
    logic [1:0]         wp_q, rp_q;
    logic [2:0]         cnt_q, cnt_d;

    logic               access;
    logic [1:0]         reg_idx;
    logic               wr_data, wr_ctrl, rd_stat;
    logic               fifo_full, fifo_empty, busy;
    logic               pop, push;
    logic               long_wait;
    logic [31:0]        status_word;

    logic               unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:9]};

    // Side effects happen only in the cycle whose ack is being generated.
    assign access  = wb_stb_i & wb_cyc_i & ~ack_q;
    assign reg_idx = wb_adr_i[3:2];
    assign wr_data = access & wb_we_i & (reg_idx == 2'd0);
    assign wr_ctrl = access & wb_we_i & (reg_idx == 2'd2);
    assign rd_stat = access & ~wb_we_i & (reg_idx == 2'd1);

    assign fifo_full   = (cnt_q == 3'd4);
    assign fifo_empty  = (cnt_q == 3'd0);
    assign busy        = (state_q != S_IDLE) | ~fifo_empty;
    assign pop         = (state_q == S_IDLE) & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push        = wr_data & (~fifo_full | pop);
    assign cnt_d       = cnt_q + {2'b00, push} - {2'b00, pop};
    assign status_word = {25'd0, cnt_q, ovf_q, fifo_empty, fifo_full, busy};

    always_comb begin
        ovf_d = ovf_q;
        if (wr_data && !push) begin
            ovf_d = 1'b1;
        end else if (rd_stat) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        dat_d = 32'd0;
        if (access && !wb_we_i) begin
            case (reg_idx)
                2'd1:    dat_d = status_word;
                2'd2:    dat_d = {31'd0, ctrl_q};
                default: dat_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q  <= 1'b0;
            dat_q  <= 32'd0;
            ctrl_q <= 1'b0;
            ovf_q  <= 1'b0;
            wp_q   <= 2'd0;
            rp_q   <= 2'd0;
            cnt_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 9'd0;
            end
        end else begin
            ack_q <= access;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (wr_ctrl) begin
                ctrl_q <= wb_dat_i[0];
            end
            if (push) begin
                fifo_q[wp_q] <= wb_dat_i[8:0];
                wp_q         <= wp_q + 2'd1;
            end
            if (pop) begin
                rp_q <= rp_q + 2'd1;
            end
        end
    end

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    assign long_wait = ~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SETUP;
                    tmr_d   = CNT_W'(T_SU - 1);
                    rs_d    = fifo_q[rp_q][8];
                    data_d  = fifo_q[rp_q][7:0];
                end
            end
            S_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = S_PULSE;
                    tmr_d   = CNT_W'(T_E - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (tmr_q == '0) begin
                    state_d = S_WAIT;
                    tmr_d   = long_wait ? CNT_W'(T_CLR - 1) : CNT_W'(T_EXEC - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // lcd_e decodes the reset-cleared state register, so reset drops it at once.
    assign lcd_e    = (state_q == S_PULSE);
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;
    assign lcd_rw   = 1'b0;
    assign lcd_bl   = ctrl_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_lcd.sv
// Bench for wb_lcd: directed and randomized bus traffic, LCD pulses recorded by a monitor
// and compared against an expected-entry queue and timing computed from the LCD timing rules.
module tb_wb_lcd;

    localparam int T_SU   = 2;
    localparam int T_E    = 4;
    localparam int T_EXEC = 10;
    localparam int T_CLR  = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stb_i, wb_cyc_i, wb_ack_o, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        lcd_rs, lcd_rw, lcd_e, lcd_bl;
    logic [7:0]  lcd_data;

    wb_lcd #(.T_SU(T_SU), .T_E(T_E), .T_EXEC(T_EXEC), .T_CLR(T_CLR)) dut (
        .clk(clk), .rst(rst),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .lcd_bl(lcd_bl)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        int unsigned rise;
        int unsigned width;
        bit          stable;
    } pulse_t;

    pulse_t     obs_q[$];
    logic [8:0] exp_q[$];

    // Pulse monitor: one record per lcd_e high period, sampled on the falling clock edge.
    pulse_t cur;
    logic   e_prev = 1'b0;
    always @(negedge clk) begin
        if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
            cur.rs = lcd_rs; cur.data = lcd_data; cur.rise = cyc; cur.width = 1; cur.stable = 1'b1;
        end else if (lcd_e === 1'b1) begin
            cur.width++;
            if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
        end else if (e_prev === 1'b1) begin
            obs_q.push_back(cur);
        end
        e_prev = lcd_e;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input logic [8:0] e);
        if (!e[8] && (e[7:0] == 8'h01 || e[7:0] == 8'h02 || e[7:0] == 8'h03)) return T_CLR;
        return T_EXEC;
    endfunction

    function automatic logic [31:0] status_exp(input int fifo_cnt, input bit fsm_active, input bit ovf);
        int busy_b, full_b, empty_b;
        busy_b  = (fsm_active || fifo_cnt != 0) ? 1 : 0;
        full_b  = (fifo_cnt == 4) ? 1 : 0;
        empty_b = (fifo_cnt == 0) ? 1 : 0;
        return 32'(busy_b + 2 * full_b + 4 * empty_b + 8 * (ovf ? 1 : 0) + 16 * fifo_cnt);
    endfunction

    function automatic logic [8:0] rand_entry();
        if ($urandom_range(0, 3) == 0) return {1'b0, 8'($urandom_range(1, 3))};
        return 9'($urandom);
    endfunction

    // One Wishbone transfer: strobe for one cycle, ack sampled one cycle later, then one idle cycle.
    task automatic wb_xfer(input logic we, input logic [1:0] reg_idx, input logic [31:0] wdat,
                           output logic [31:0] rdat, output int unsigned ack_cyc);
        wb_adr_i = {28'($urandom), reg_idx, 2'($urandom)};
        wb_sel_i = 4'($urandom);
        wb_we_i  = we;
        wb_dat_i = wdat;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(negedge clk);
        check("ack_rise", 32'(wb_ack_o), 32'd1);
        rdat    = wb_dat_o;
        ack_cyc = cyc;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
        check("ack_single", 32'(wb_ack_o), 32'd0);
        check("dat_no_ack", wb_dat_o, 32'd0);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, output int unsigned ac);
        logic [31:0] ignored;
        wb_xfer(1'b1, r, d, ignored, ac);
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] d);
        int unsigned ac;
        wb_xfer(1'b0, r, 32'($urandom), d, ac);
    endtask

    task automatic push_data(input logic [8:0] e, output int unsigned ac);
        exp_q.push_back(e);
        wr(2'd0, {23'($urandom), e}, ac);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("pulses_within_budget", 32'(obs_q.size() >= n), 32'd1);
    endtask

    task automatic compare_pulses(input int n, input int unsigned first_rise, output int unsigned last_fall);
        int unsigned r_exp = first_rise;
        pulse_t      p;
        logic [8:0]  e;
        last_fall = first_rise + T_E;
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() == 0) begin
                check("pulse_present", 32'(obs_q.size()), 32'd1);
                break;
            end
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            check("pulse_rs", 32'(p.rs), 32'(e[8]));
            check("pulse_data", 32'(p.data), 32'(e[7:0]));
            check("pulse_width", 32'(p.width), 32'(T_E));
            check("pulse_stable", 32'(p.stable), 32'd1);
            check("pulse_rise", 32'(p.rise), 32'(r_exp));
            last_fall = r_exp + T_E;
            r_exp     = last_fall + wait_of(e) + 1 + T_SU;
        end
    endtask

    // Status sampled on the last WAIT cycle must still be busy; shortly after, idle and empty.
    task automatic check_wait_end(input int unsigned fall, input int wlen);
        logic [31:0] s;
        int guard = 0;
        while (cyc + 1 < fall + wlen && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        rd(2'd1, s);
        check("status_last_wait", s, status_exp(0, 1'b1, 1'b0));
        rd(2'd1, s);
        check("status_idle", s, status_exp(0, 1'b0, 1'b0));
    endtask

    initial begin
        logic [31:0] s;
        logic [8:0]  e, last_e;
        int unsigned ack, first_ack, fall;
        int          mcnt;
        bit          movf;
        int          guard;

        rst = 1'b1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_lcd_e", 32'(lcd_e), 32'd0);
        check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        check("rst_lcd_data", 32'(lcd_data), 32'd0);
        check("rst_lcd_bl", 32'(lcd_bl), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd(2'd1, s);
        check("status_after_reset", s, status_exp(0, 1'b0, 1'b0));

        // Single command byte from idle.
        push_data(9'h038, ack);
        wait_pulses(1, 100);
        compare_pulses(1, ack + T_SU + 1, fall);
        check_wait_end(fall, T_EXEC);
        check("hold_rs", 32'(lcd_rs), 32'd0);
        check("hold_data", 32'(lcd_data), 32'h38);

        // Clear command then a data byte: long then short wait.
        push_data(9'h001, ack);
        first_ack = ack;
        push_data(9'h141, ack);
        wait_pulses(2, 200);
        compare_pulses(2, first_ack + T_SU + 1, fall);
        check_wait_end(fall, T_EXEC);
        check("hold_rs_data", 32'(lcd_rs), 32'd1);
        check("hold_data_a", 32'(lcd_data), 32'h41);

        // Strobe held for two cycles: one ack, one push.
        exp_q.push_back(9'h155);
        wb_adr_i = 32'h0; wb_sel_i = 4'hF; wb_we_i = 1'b1; wb_dat_i = 32'h155;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(negedge clk);
        check("hold_ack_first", 32'(wb_ack_o), 32'd1);
        ack = cyc;
        @(negedge clk);
        check("hold_ack_second", 32'(wb_ack_o), 32'd0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        wait_pulses(1, 100);
        compare_pulses(1, ack + T_SU + 1, fall);
        check_wait_end(fall, T_EXEC);
        repeat (30) @(negedge clk);
        check("hold_single_pulse", 32'(obs_q.size()), 32'd0);

        // Six writes during a clear's WAIT: four queued, overflow sticky until read.
        push_data(9'h001, ack);
        wait_pulses(1, 100);
        compare_pulses(1, ack + T_SU + 1, fall);
        mcnt = 0; movf = 1'b0; last_e = 9'h0;
        for (int j = 0; j < 6; j++) begin
            e = rand_entry();
            if (mcnt < 4) begin
                exp_q.push_back(e);
                last_e = e;
                mcnt++;
            end else begin
                movf = 1'b1;
            end
            wr(2'd0, {23'($urandom), e}, ack);
        end
        rd(2'd1, s);
        check("status_overflow", s, status_exp(mcnt, 1'b1, movf));
        rd(2'd1, s);
        check("status_ovf_cleared", s, status_exp(mcnt, 1'b1, 1'b0));
        wait_pulses(4, 400);
        compare_pulses(4, fall + T_CLR + 1 + T_SU, fall);
        check_wait_end(fall, wait_of(last_e));
        check("overflow_dropped", 32'(obs_q.size()), 32'd0);

        // Control register and unmapped word.
        wr(2'd2, 32'h1, ack);
        check("lcd_bl_on", 32'(lcd_bl), 32'd1);
        rd(2'd2, s);
        check("ctrl_read", s, 32'h1);
        rd(2'd3, s);
        check("reg_0c_read", s, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF, ack);
        rd(2'd2, s);
        check("ctrl_unchanged", s, 32'h1);
        rd(2'd1, s);
        check("status_no_push", s, status_exp(0, 1'b0, 1'b0));

        // Randomized bursts from idle.
        for (int r = 0; r < 8; r++) begin
            int k;
            k = $urandom_range(1, 4);
            first_ack = 0;
            for (int j = 0; j < k; j++) begin
                e = rand_entry();
                push_data(e, ack);
                if (j == 0) first_ack = ack;
            end
            wait_pulses(k, 400);
            compare_pulses(k, first_ack + T_SU + 1, fall);
            check_wait_end(fall, wait_of(e));
            check("burst_no_extra", 32'(obs_q.size()), 32'd0);
        end

        // Reset during PULSE with entries still queued.
        for (int j = 0; j < 3; j++) begin
            push_data(rand_entry(), ack);
        end
        guard = 0;
        while (lcd_e !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("reached_pulse", 32'(lcd_e), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_lcd_e", 32'(lcd_e), 32'd0);
        check("rst_async_lcd_data", 32'(lcd_data), 32'd0);
        check("rst_async_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_async_lcd_bl", 32'(lcd_bl), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        rd(2'd1, s);
        check("status_after_mid_reset", s, status_exp(0, 1'b0, 1'b0));
        repeat (150) @(negedge clk);
        check("no_pulse_after_reset", 32'(obs_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
